// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues req/ack word reads to instruction
// memory and queues {inst, pc} pairs for decode behind a valid/ready handshake.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [29:0] RESET_PC = 30'h100000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [29:0] out_pc,
    input  logic        out_ready,
    input  logic        redirect,
    input  logic [29:0] redirect_pc
);
    localparam int               PTR_W = $clog2(DEPTH);
    localparam int               CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    // DRAIN holds an abandoned request until memory completes it.
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [29:0] pc;
    } entry_t;

    state_t           state;
    entry_t           fifo [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [29:0]      fetch_pc;
    logic             push;
    logic             pop;

    assign mem_req   = (state == REQ) || (state == DRAIN);
    assign out_valid = (count != '0);
    assign out_inst  = fifo[rd_ptr].inst;
    assign out_pc    = fifo[rd_ptr].pc;

    // Redirect outranks both push and pop.
    assign push = (state == REQ) && mem_ack && !redirect;
    assign pop  = out_valid && out_ready && !redirect;

    // NOTE: default assignment first so every path drives count_next and no latch is inferred.
    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CNT_W'(1);
        else if (pop && !push)
            count_next = count - CNT_W'(1);
    end

    // NOTE: the storage array is deliberately not reset; out_valid gates whatever it holds.
    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= {mem_rdata, mem_addr};
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fetch_pc <= RESET_PC;
            mem_addr <= RESET_PC;
        end else begin
            if (redirect) begin
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fetch_pc <= redirect_pc;
            end else begin
                count <= count_next;
                if (push) begin
                    wr_ptr   <= wr_ptr + PTR_W'(1);
                    fetch_pc <= fetch_pc + 30'd1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
            end

            unique case (state)
                IDLE: begin
                    if (!redirect && (count < FULL)) begin
                        state    <= REQ;
                        mem_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    // mem_addr is held on entry to DRAIN so the pending request stays stable.
                    if (redirect)
                        state <= mem_ack ? IDLE : DRAIN;
                    else if (mem_ack) begin
                        if (count_next < FULL)
                            mem_addr <= fetch_pc + 30'd1;
                        else
                            state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (mem_ack)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a queue model.
module tb_inst_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [29:0] RESET_PC = 30'h100000;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [29:0] out_pc;
    logic        out_ready;
    logic        redirect;
    logic [29:0] redirect_pc;
    logic [31:0] salt;

    int n_cmp = 0;
    int n_bad = 0;
    bit live  = 0;

    // Reference model: a pending-request flag, a drain flag, the request
    // address, the next fetch address and a plain queue of {inst, pc}.
    bit          m_req;
    bit          m_drain;
    logic [29:0] m_addr;
    logic [29:0] m_pc;
    logic [61:0] q [$];

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .out_ready  (out_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    // Instruction memory returns an address-dependent word scrambled per cycle.
    assign mem_rdata = salt ^ {mem_addr, 2'b01};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int size0;
        size0 = q.size();
        if (reset) begin
            m_req   = 1'b0;
            m_drain = 1'b0;
            m_pc    = RESET_PC;
            m_addr  = RESET_PC;
            q.delete();
            return;
        end
        if (redirect) begin
            q.delete();
            m_pc = redirect_pc;
            if (m_req && mem_ack) begin
                m_req   = 1'b0;
                m_drain = 1'b0;
            end else if (m_req) begin
                m_drain = 1'b1;
            end
            return;
        end
        if (size0 != 0 && out_ready)
            void'(q.pop_front());
        if (!m_req) begin
            if (size0 < DEPTH) begin
                m_req  = 1'b1;
                m_addr = m_pc;
            end
        end else if (mem_ack) begin
            if (m_drain) begin
                m_req   = 1'b0;
                m_drain = 1'b0;
            end else begin
                q.push_back({mem_rdata, m_addr});
                m_pc = m_pc + 30'd1;
                if (q.size() < DEPTH)
                    m_addr = m_pc;
                else
                    m_req = 1'b0;
            end
        end
    endtask

    // Compare on the falling edge, then advance the model across the next rising edge.
    always @(negedge clk) begin
        if (live) begin
            check("mem_req", 64'(mem_req), 64'(m_req));
            if (m_req)
                check("mem_addr", 64'(mem_addr), 64'(m_addr));
            check("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                check("out_pc", 64'(out_pc), 64'(q[0][29:0]));
                check("out_inst", 64'(out_inst), 64'(q[0][61:30]));
            end
        end
        model_step();
    end

    task automatic drive(input logic r, input logic a, input logic rdy,
                         input logic rd, input logic [29:0] rpc);
        reset       = r;
        mem_ack     = a;
        out_ready   = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        salt        = $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 30'h0);
        tick();
        live = 1'b1;
        tick();
    endtask

    initial begin
        logic [29:0] exp_pc;
        logic [29:0] rpc;
        int          ack_pct;
        int          rdy_pct;

        drive(1'b1, 1'b0, 1'b0, 1'b0, 30'h0);

        // Reset state, then streaming with zero-wait memory and ready decode.
        do_reset();
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        drive(1'b0, 1'b1, 1'b1, 1'b0, 30'h0);
        tick();
        check("first_req", 64'(mem_req), 64'(1));
        check("first_addr", 64'(mem_addr), 64'(30'h100000));
        check("no_bypass", 64'(out_valid), 64'(0));
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stream_valid", 64'(out_valid), 64'(1));
            check("stream_pc", 64'(out_pc), 64'(30'h100000 + 30'(i)));
        end

        // Stalled decode: four pushes fill the queue, one pop re-arms fetch.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 30'h0);
        for (int i = 0; i < 5; i++) tick();
        check("full_no_req", 64'(mem_req), 64'(0));
        check("full_head", 64'(out_pc), 64'(30'h100000));
        tick();
        tick();
        check("full_hold_req", 64'(mem_req), 64'(0));
        drive(1'b0, 1'b1, 1'b1, 1'b0, 30'h0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 30'h0);
        check("after_pop_head", 64'(out_pc), 64'(30'h100001));
        tick();
        check("rearm_req", 64'(mem_req), 64'(1));
        check("rearm_addr", 64'(mem_addr), 64'(30'h100004));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 30'h0);
        tick();

        // Redirect while a slow request is outstanding: drain then refetch.
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 30'h0);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 30'h200);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 30'h0);
        check("drain_req", 64'(mem_req), 64'(1));
        check("drain_addr", 64'(mem_addr), 64'(30'h100000));
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 30'h0);
        tick();
        check("drained_req", 64'(mem_req), 64'(0));
        check("drained_valid", 64'(out_valid), 64'(0));
        tick();
        check("redir_addr", 64'(mem_addr), 64'(30'h200));
        tick();
        check("redir_head", 64'(out_pc), 64'(30'h200));

        // Redirect coinciding with an ack: response dropped.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 30'h0);
        tick();
        tick();
        tick();
        check("pre_redir_addr", 64'(mem_addr), 64'(30'h100002));
        drive(1'b0, 1'b1, 1'b0, 1'b1, 30'h40);
        tick();
        check("ack_redir_valid", 64'(out_valid), 64'(0));
        check("ack_redir_req", 64'(mem_req), 64'(0));
        drive(1'b0, 1'b1, 1'b0, 1'b0, 30'h0);
        tick();
        check("ack_redir_addr", 64'(mem_addr), 64'(30'h40));

        // Fetch PC wrap-around.
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 30'h3FFFFFFE);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 30'h0);
        tick();
        check("wrap_addr", 64'(mem_addr), 64'(30'h3FFFFFFE));
        exp_pc = 30'h3FFFFFFE;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wrap_pc", 64'(out_pc), 64'(exp_pc));
            exp_pc = exp_pc + 30'd1;
        end

        // Reset while a request awaits ack with two entries queued.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 30'h0);
        tick();
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 30'h0);
        tick();
        check("mid_req", 64'(mem_req), 64'(1));
        check("mid_valid", 64'(out_valid), 64'(1));
        drive(1'b1, 1'b0, 1'b0, 1'b0, 30'h0);
        tick();
        check("mid_rst_req", 64'(mem_req), 64'(0));
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 30'h0);
        tick();
        check("post_rst_addr", 64'(mem_addr), 64'(30'h100000));

        // Randomized traffic; the model checks every cycle.
        for (int epoch = 0; epoch < 3; epoch++) begin
            ack_pct = (epoch == 0) ? 100 : (epoch == 1) ? 50 : 20;
            rdy_pct = (epoch == 0) ? 40 : (epoch == 1) ? 80 : 60;
            for (int cyc = 0; cyc < 1000; cyc++) begin
                if ($urandom_range(0, 3) == 0)
                    rpc = 30'h3FFFFFFC + 30'($urandom_range(0, 3));
                else
                    rpc = 30'($urandom);
                drive($urandom_range(0, 299) == 0,
                      $urandom_range(0, 99) < ack_pct,
                      $urandom_range(0, 99) < rdy_pct,
                      $urandom_range(0, 24) == 0,
                      rpc);
                tick();
            end
        end

        drive(1'b0, 1'b0, 1'b0, 1'b0, 30'h0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
